// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS32 control path.
// States, opcode/funct constants, ALU codes and mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // 11 means "no ALU operation": control reads as 000
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU control decode from the FSM's alu_op and the R-type funct.
// Flags funct values the core does not implement.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  // Map operation class (and funct for R-type) to an ALU code
  always_comb begin
    alu_control   = ALU_AND;
    funct_illegal = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle MIPS32 core.
// Sequences fetch/decode/execute/memory/writeback, halts on bad opcodes.
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       halted
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       funct_illegal;

  alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ALU operation class per state, kept apart from the main decode
  always_comb begin
    alu_op = ALUOP_NONE;
    unique case (state_q)
      S_FETCH, S_DECODE,
      S_MEMADR, S_ADDIEX: alu_op = ALUOP_ADD;
      S_BEQEX, S_BNEEX:   alu_op = ALUOP_SUB;
      S_RTYPEEX:          alu_op = ALUOP_FUNCT;
      default:            alu_op = ALUOP_NONE;
    endcase
  end

  // Next state and Moore outputs (branch pc_en also sees zero)
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PC_ALU;
    instr_done = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        state_d   = funct_illegal ? S_HALT : S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alu_src_a  = 1'b1;
        pc_src     = PC_ALUOUT;
        pc_en      = (state_q == S_BEQEX) ? zero : ~zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pc_src     = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control unit for the multicycle MIPS32 core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath enable and mux select inside `top`. It consumes the instruction-register opcode/funct and the ALU zero flag. It also produces a per-instruction retire pulse and a halt flag that the simulation bench uses to end runs.

## Interface
- No parameters; all encodings come from the shared package.
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instr[31:26] from the instruction register
- `funct`  in  6  instr[5:0] from the instruction register
- `zero`  in  1  ALU result == 0 (combinational from datapath)
- `pc_en`  out  1  PC register load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  data memory write strobe
- `ir_write`  out  1  instruction register load
- `reg_write`  out  1  register file write
- `reg_dst`  out  1  write index: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `alu_src_a`  out  1  0 = PC, 1 = reg A
- `alu_src_b`  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_control`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `instr_done`  out  1  one-cycle pulse in the last state of every instruction
- `halted`  out  1  sticky; set on an unsupported opcode/funct

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX, HALT.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - lw/sw (0x23/0x2B) → MEMADR
  - R-type (0x00) → RTYPEEX
  - beq (0x04) → BEQEX
  - bne (0x05) → BNEEX
  - addi (0x08) → ADDIEX
  - j (0x02) → JEX
  - any other opcode → HALT
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state is MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state is FETCH.
- MEMWR: iord=1, mem_write=1, instr_done=1. Next state is FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_control decoded from funct (see below). Next state is RTYPEWB.
  - Supported funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other funct → HALT (from RTYPEEX, instead of RTYPEWB).
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state is FETCH.
- BEQEX / BNEEX: alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_en = zero for BEQEX, pc_en = ~zero for BNEEX.
  - instr_done=1. Next state is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Next state is ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state is FETCH.
- JEX: pc_src=10, pc_en=1, instr_done=1. Next state is FETCH.
- HALT: all enables and strobes are 0, halted=1. The FSM stays in HALT until `rst`.
- Any control output not listed for a state is 0.

## Timing
- Reset: state=FETCH immediately (async). Outputs then show FETCH values (pc_en=1, ir_write=1, alu_src_b=01, alu_control=010, all others 0), and halted=0.
  - Datapath registers are also held in reset, so no fetch commits until the first rising edge after `rst` falls.
- Reset asserted mid-instruction: abandon the instruction immediately. No partial writeback occurs after assertion.
- State register updates on the rising clk edge only.
- All outputs are combinational from state, except pc_en in BEQEX/BNEEX, which also depends on `zero` in the same cycle.
- Cycles per instruction, counted FETCH to last state inclusive:
  - lw 5
  - sw, R-type, addi 4
  - beq, bne, j 3
- instr_done is high for exactly one cycle per instruction and never in HALT.
- The opcode decode is sampled in DECODE; the funct decode is sampled in RTYPEEX.

## Structure
- Package `mips_pkg` holds:
  - the state enum (4-bit encoding)
  - opcode and funct constants
  - ALU control codes
  - alu_src_b and pc_src select codes
- One sub-module, `alu_decoder`: maps (alu_op[1:0], funct) to alu_control plus a `funct_illegal` flag.
  - alu_op codes: 00 add, 01 sub, 10 funct-driven.
- The FSM owns all other logic.

## Test plan
- Reset release, then lw (opcode 0x23): states FETCH→DECODE→MEMADR→MEMRD→MEMWB. reg_write=1 with mem_to_reg=1 in cycle 5, and instr_done pulses in cycle 5 only.
- sw (0x2B): mem_write=1 and iord=1 in cycle 4 only, reg_write never asserted, return to FETCH in cycle 5.
- R-type funct 0x22 then 0x2A: alu_control=110 then 111 in RTYPEEX, and reg_dst=1 in RTYPEWB.
- beq with zero=1 → pc_en=1 and pc_src=01 in cycle 3; beq with zero=0 → pc_en=0; bne with zero=0 → pc_en=1.
- Opcode 0x3F, and separately R-type funct 0x00 → halted=1 and all strobes 0 for 20 cycles; after rst pulse, halted=0 and state=FETCH.
- Assert rst during MEMRD of lw: state=FETCH within the same cycle, and no reg_write is seen afterwards.
